// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared definitions for the RV32I multicycle control unit:
//                FSM state enumeration, opcode constants, ALU operation
//                codes and datapath mux-select encodings.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  // Opcodes (instruction[6:0])
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // Internal ALUOp between FSM and ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUControl codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ImmSrc encodings
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA encodings
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decoder
//  Description : Combinational ALU operation decode from ALUOp and the
//                instruction function fields.
//  Ports       : ALUOp[1:0]      in  operation class from the FSM
//                funct3[2:0]     in  instruction[14:12]
//                op5             in  instruction[5] (R-type vs I-type)
//                funct7b5        in  instruction[30]
//                ALUControl[2:0] out ALU operation code
//  Revision    : 1.0  initial release
// ============================================================================
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only means subtract for R-type; addi reuses that bit
          // as part of its immediate, hence the op5 qualifier.
          3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Main control unit of the RV32I multicycle core. Moore FSM
//                sequencing fetch/decode/execute/memory/writeback and
//                driving all datapath enables and mux selects.
//  Ports       : clk, reset (sync, active-high)
//                op[6:0], funct3[2:0], funct7b5, Zero       inputs
//                PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite enables
//                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl selects
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_alu_op;
  logic       w_pc_update;
  logic       w_branch;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_I:         w_next = S_EXECUTEI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_FETCH;  // unsupported: drop it, no writes
        endcase
      end
      S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_JAL:      w_next = S_ALUWB;
      default:    w_next = S_FETCH;  // MEMWB, MEMWRITE, ALUWB, BEQ
    endcase
  end

  // Moore output decode
  always_comb begin
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RD2;
    w_alu_op    = ALUOP_ADD;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    case (r_state)
      S_FETCH: begin
        IRWrite     = 1'b1;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
        w_pc_update = 1'b1;
      end
      S_DECODE: begin
        // Branch target PC+imm precomputed here into ALUOut
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA  = SRCA_RD1;
        w_alu_op = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA  = SRCA_RD1;
        ALUSrcB  = SRCB_IMM;
        w_alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_JAL: begin
        // Link value OldPC+4; PC takes the target held in ALUOut
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_FOUR;
        w_pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = SRCA_RD1;
        w_alu_op = ALUOP_SUB;
        w_branch = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite = w_pc_update | (w_branch & Zero);

  // Immediate format depends on the opcode only
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .ALUOp      (w_alu_op),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .ALUControl (ALUControl)
  );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control. A table of
//                per-cycle vectors walks every instruction class; hand
//                sequences cover reset, BEQ Zero toggling and reset abort.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int n_checks = 0;
  int n_fail   = 0;

  // Packed outputs: {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,RegWrite}
  logic [15:0] w_got;
  assign w_got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ImmSrc, ALUControl, RegWrite};

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [15:0] exp;
  } vec_t;

  vec_t vq[$];

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_BAD = 7'b1111111;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .RegWrite   (RegWrite)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic [6:0] o, logic [2:0] f3,
                              logic f7, logic z, logic [15:0] e);
    vec_t v;
    v.name = n; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = e;
    return v;
  endfunction

  // R-type: FETCH, DECODE, EXECUTER, ALUWB with the given ALUControl
  task automatic add_r(string n, logic [2:0] f3, logic f7, logic [2:0] c);
    vq.push_back(mk({n, " F"},  T_R, f3, f7, 1'b0, 16'b1_0_0_1_10_00_10_00_000_0));
    vq.push_back(mk({n, " D"},  T_R, f3, f7, 1'b0, 16'b0_0_0_0_00_01_01_00_000_0));
    vq.push_back(mk({n, " EX"}, T_R, f3, f7, 1'b0, {9'b0_0_0_0_00_10_0, 4'b0_00_0, 3'b0} | {13'b0, c} << 1));
    vq.push_back(mk({n, " WB"}, T_R, f3, f7, 1'b0, 16'b0_0_0_0_00_00_00_00_000_1));
  endtask

  task automatic add_i(string n, logic [2:0] f3, logic f7, logic [2:0] c);
    vq.push_back(mk({n, " F"},  T_I, f3, f7, 1'b0, 16'b1_0_0_1_10_00_10_00_000_0));
    vq.push_back(mk({n, " D"},  T_I, f3, f7, 1'b0, 16'b0_0_0_0_00_01_01_00_000_0));
    vq.push_back(mk({n, " EX"}, T_I, f3, f7, 1'b0, 16'b0_0_0_0_00_10_01_00_000_0 | {12'b0, c, 1'b0}));
    vq.push_back(mk({n, " WB"}, T_I, f3, f7, 1'b0, 16'b0_0_0_0_00_00_00_00_000_1));
  endtask

  task automatic check1(string n, logic got, logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", n, got, exp);
    end
  endtask

  task automatic check_vec(string n, logic [15:0] exp);
    n_checks++;
    if (w_got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", n, w_got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; op = T_LW; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;

    // --- lw: 5 cycles
    vq.push_back(mk("lw F",  T_LW, 3'b010, 1'b0, 1'b0, 16'b1_0_0_1_10_00_10_00_000_0));
    vq.push_back(mk("lw D",  T_LW, 3'b010, 1'b0, 1'b0, 16'b0_0_0_0_00_01_01_00_000_0));
    vq.push_back(mk("lw MA", T_LW, 3'b010, 1'b0, 1'b0, 16'b0_0_0_0_00_10_01_00_000_0));
    vq.push_back(mk("lw MR", T_LW, 3'b010, 1'b0, 1'b0, 16'b0_1_0_0_00_00_00_00_000_0));
    vq.push_back(mk("lw WB", T_LW, 3'b010, 1'b0, 1'b0, 16'b0_0_0_0_01_00_00_00_000_1));
    // --- sw: 4 cycles
    vq.push_back(mk("sw F",  T_SW, 3'b010, 1'b0, 1'b0, 16'b1_0_0_1_10_00_10_01_000_0));
    vq.push_back(mk("sw D",  T_SW, 3'b010, 1'b0, 1'b0, 16'b0_0_0_0_00_01_01_01_000_0));
    vq.push_back(mk("sw MA", T_SW, 3'b010, 1'b0, 1'b0, 16'b0_0_0_0_00_10_01_01_000_0));
    vq.push_back(mk("sw MW", T_SW, 3'b010, 1'b0, 1'b0, 16'b0_1_1_0_00_00_00_01_000_0));
    // --- R-type variants
    add_r("sub",   3'b000, 1'b1, 3'b001);
    add_r("add",   3'b000, 1'b0, 3'b000);
    add_r("and",   3'b111, 1'b0, 3'b010);
    add_r("or",    3'b110, 1'b0, 3'b011);
    add_r("slt",   3'b010, 1'b0, 3'b101);
    add_r("sll",   3'b001, 1'b1, 3'b000);
    // --- I-type: funct7b5 must not turn addi into sub
    add_i("addi",  3'b000, 1'b1, 3'b000);
    add_i("ori",   3'b110, 1'b0, 3'b011);
    // --- beq taken / not taken: 3 cycles
    vq.push_back(mk("beqT F", T_BEQ, 3'b000, 1'b0, 1'b1, 16'b1_0_0_1_10_00_10_10_000_0));
    vq.push_back(mk("beqT D", T_BEQ, 3'b000, 1'b0, 1'b1, 16'b0_0_0_0_00_01_01_10_000_0));
    vq.push_back(mk("beqT B", T_BEQ, 3'b000, 1'b0, 1'b1, 16'b1_0_0_0_00_10_00_10_001_0));
    vq.push_back(mk("beqN F", T_BEQ, 3'b000, 1'b0, 1'b0, 16'b1_0_0_1_10_00_10_10_000_0));
    vq.push_back(mk("beqN D", T_BEQ, 3'b000, 1'b0, 1'b0, 16'b0_0_0_0_00_01_01_10_000_0));
    vq.push_back(mk("beqN B", T_BEQ, 3'b000, 1'b0, 1'b0, 16'b0_0_0_0_00_10_00_10_001_0));
    // --- jal: 4 cycles
    vq.push_back(mk("jal F",  T_JAL, 3'b000, 1'b0, 1'b0, 16'b1_0_0_1_10_00_10_11_000_0));
    vq.push_back(mk("jal D",  T_JAL, 3'b000, 1'b0, 1'b0, 16'b0_0_0_0_00_01_01_11_000_0));
    vq.push_back(mk("jal J",  T_JAL, 3'b000, 1'b0, 1'b0, 16'b1_0_0_0_00_01_10_11_000_0));
    vq.push_back(mk("jal WB", T_JAL, 3'b000, 1'b0, 1'b0, 16'b0_0_0_0_00_00_00_11_000_1));
    // --- unsupported opcode: 2 cycles, no writes
    vq.push_back(mk("bad F",  T_BAD, 3'b000, 1'b0, 1'b0, 16'b1_0_0_1_10_00_10_00_000_0));
    vq.push_back(mk("bad D",  T_BAD, 3'b000, 1'b0, 1'b0, 16'b0_0_0_0_00_01_01_00_000_0));

    // Reset held for two edges, then released
    step();
    step();
    reset = 1'b0;
    #1;
    check_vec("reset FETCH", 16'b1_0_0_1_10_00_10_00_000_0);

    // Table walk: each row is one clock cycle
    foreach (vq[i]) begin
      op = vq[i].op; funct3 = vq[i].f3; funct7b5 = vq[i].f7; Zero = vq[i].z;
      #1;
      check_vec(vq[i].name, vq[i].exp);
      step();
    end

    // After the unsupported opcode the FSM must be back in FETCH
    op = T_BEQ; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
    #1;
    check1("bad->FETCH IRWrite", IRWrite, 1'b1);
    step();
    step();
    // BEQ: PCWrite follows Zero combinationally within the state
    Zero = 1'b1; #1;
    check1("beq Zero=1 PCWrite", PCWrite, 1'b1);
    Zero = 1'b0; #1;
    check1("beq Zero=0 PCWrite", PCWrite, 1'b0);
    step();
    check1("beq->FETCH IRWrite", IRWrite, 1'b1);

    // addi interrupted by reset in ALUWB
    op = T_I; funct3 = 3'b000;
    step(); step(); step();
    check1("addi ALUWB RegWrite", RegWrite, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check1("post-reset RegWrite", RegWrite, 1'b0);
    check1("post-reset MemWrite", MemWrite, 1'b0);
    check1("post-reset IRWrite", IRWrite, 1'b1);

    // Following addi runs normally: RegWrite only in its 4th cycle
    for (int c = 1; c <= 4; c++) begin
      check1($sformatf("addi2 c%0d RegWrite", c), RegWrite, (c == 4));
      step();
    end
    check1("addi2 ->FETCH IRWrite", IRWrite, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
